stage_writeback: RTL



---
 rtl/stage_writeback_pkg.sv | 39 +++
 rtl/stage_writeback_wb_write_select.sv | 39 +++
 rtl/stage_writeback.sv | 127 ++++++++++++
 3 files changed

// File: rtl/stage_writeback_pkg.sv
// rtl/stage_writeback_pkg.sv - shared types, opcodes and stage helpers for the writeback stage (WB_TRACE_EN enables STAGE_PRINT)
package stage_writeback_pkg;

   typedef logic [7:0]  V8;
   typedef logic [15:0] V16;
   typedef logic [31:0] V32;

   localparam V8 OP_NOP = 8'h00;
   localparam V8 OP_ADD = 8'h01;
   localparam V8 OP_SUB = 8'h02;
   localparam V8 OP_AND = 8'h03;
   localparam V8 OP_WRL = 8'h04;
   localparam V8 OP_RDL = 8'h05;

   // valid=0 marks a bubble; a real NOP instruction has valid=1
   typedef struct packed {
      logic valid;
      V16   pc;
      V8    operation;
      V8    rw;
      V32   res;
   } t_stage;

   localparam t_stage STAGE_BUBBLE = '{valid: 1'b0, pc: '0, operation: OP_NOP, rw: '0, res: '0};

   typedef enum logic [0:0] {
      WB_IDLE      = 1'b0,
      WB_WAIT_LOAD = 1'b1
   } t_wb_state;

endpackage

`ifndef STAGE_WRITEBACK_MACROS
`define STAGE_WRITEBACK_MACROS
`define STAGE_FLUSH stage_writeback_pkg::STAGE_BUBBLE
`ifdef WB_TRACE_EN
`define STAGE_PRINT(s) $display("WB valid=%0b pc=%h op=%h rw=%h res=%h", (s).valid, (s).pc, (s).operation, (s).rw, (s).res)
`endif
`endif

// File: rtl/stage_writeback_wb_write_select.sv
// rtl/stage_writeback_wb_write_select.sv - combinational write/retire decision for one instruction
import stage_writeback_pkg::*;

module wb_write_select #(
   parameter int R0_HARDWIRED = 1
) (
   input  t_stage     instr,
   input  logic       mem_data_valid,
   input  logic [31:0] mem_data,
   output logic       write_enable,
   output logic [7:0] rw,
   output logic [31:0] data,
   output logic       retire,
   output logic       need_wait
);

   logic is_alu;
   logic is_rdl;
   logic is_wrl;
   logic commit_write;
   logic r0_block;

   // classify the instruction and decide whether it writes, retires or must wait for load data
   always_comb begin
      is_alu       = instr.valid && ((instr.operation == OP_ADD) ||
                                     (instr.operation == OP_SUB) ||
                                     (instr.operation == OP_AND));
      is_rdl       = instr.valid && (instr.operation == OP_RDL);
      is_wrl       = instr.valid && (instr.operation == OP_WRL);
      commit_write = is_alu || (is_rdl && mem_data_valid);
      r0_block     = (R0_HARDWIRED != 0) && (instr.rw == 8'd0);
      write_enable = commit_write && !r0_block;
      rw           = instr.rw;
      data         = is_rdl ? mem_data : instr.res;
      retire       = commit_write || is_wrl;
      need_wait    = is_rdl && !mem_data_valid;
   end

endmodule

// File: rtl/stage_writeback.sv
// rtl/stage_writeback.sv - final pipeline stage driving the register-bank write port (WB_TRACE_EN adds trace prints)
import stage_writeback_pkg::*;

module stage_writeback #(
   parameter int RETIRE_W     = 32,
   parameter int R0_HARDWIRED = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                flush,
   input  t_stage              stage_mem,
   input  logic                mem_data_valid,
   input  logic [31:0]         mem_data,
   output logic                write_enable,
   output logic [7:0]          rw,
   output logic [31:0]         data,
   output t_stage              stage_wb,
   output logic                wb_busy,
   output logic [RETIRE_W-1:0] retired
);

   t_wb_state           state;
   t_wb_state           state_n;
   t_stage              stage_wb_n;
   logic                write_enable_n;
   logic [7:0]          rw_n;
   logic [31:0]         data_n;
   logic                wb_busy_n;
   logic [RETIRE_W-1:0] retired_n;

   t_stage              sel_instr;
   logic                sel_we;
   logic [7:0]          sel_rw;
   logic [31:0]         sel_data;
   logic                sel_retire;
   logic                sel_wait;

   // while waiting, the held load is re-evaluated against incoming cache data
   assign sel_instr = (state == WB_WAIT_LOAD) ? stage_wb : stage_mem;

   wb_write_select #(
      .R0_HARDWIRED(R0_HARDWIRED)
   ) u_write_select (
      .instr          (sel_instr),
      .mem_data_valid (mem_data_valid),
      .mem_data       (mem_data),
      .write_enable   (sel_we),
      .rw             (sel_rw),
      .data           (sel_data),
      .retire         (sel_retire),
      .need_wait      (sel_wait)
   );

   // next-state and next-output logic; write strobe defaults low so a write never repeats
   always_comb begin
      state_n        = state;
      stage_wb_n     = stage_wb;
      write_enable_n = 1'b0;
      rw_n           = rw;
      data_n         = data;
      retired_n      = retired;
      case (state)
         WB_IDLE: begin
            if (!stall) begin
               if (flush) begin
                  stage_wb_n = `STAGE_FLUSH;
               end else begin
                  stage_wb_n = stage_mem;
                  if (sel_we) begin
                     write_enable_n = 1'b1;
                     rw_n           = sel_rw;
                     data_n         = sel_data;
                  end
                  if (sel_retire) retired_n = retired + RETIRE_W'(1);
                  if (sel_wait)   state_n   = WB_WAIT_LOAD;
               end
            end
         end
         WB_WAIT_LOAD: begin
            if (mem_data_valid) begin
               if (sel_we) begin
                  write_enable_n = 1'b1;
                  rw_n           = sel_rw;
                  data_n         = sel_data;
               end
               if (sel_retire) retired_n = retired + RETIRE_W'(1);
               state_n = WB_IDLE;
            end
         end
         default: state_n = WB_IDLE;
      endcase
      wb_busy_n = (state_n == WB_WAIT_LOAD);
   end

   // state and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= WB_IDLE;
         stage_wb     <= `STAGE_FLUSH;
         write_enable <= 1'b0;
         rw           <= '0;
         data         <= '0;
         wb_busy      <= 1'b0;
         retired      <= '0;
      end else begin
         state        <= state_n;
         stage_wb     <= stage_wb_n;
         write_enable <= write_enable_n;
         rw           <= rw_n;
         data         <= data_n;
         wb_busy      <= wb_busy_n;
         retired      <= retired_n;
      end
   end

`ifdef WB_TRACE_EN
   // trace of the committed bundle and any register write
   always @(negedge clock) begin
      if (!reset) begin
         `STAGE_PRINT(stage_wb);
         if (write_enable) $display("WB write rw=%h data=%h", rw, data);
      end
   end
`endif

endmodule
